// File: rtl/mem_arb_pkg.sv
// Shared types, widths and helpers for the two-port program/data RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned MEM_DEPTH = 9;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Full-width compare so high address bits can never alias into the RAM.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational two-way round-robin picker; the last-grant pointer is held by the caller.
module mem_rr_pick
  import mem_arb_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic last_grant,
  output logic win_c,
  output logic valid_c
);

  always_comb begin
    valid_c = f_req | d_req;
    win_c   = PORT_F;
    if (f_req && d_req) begin
      win_c = (last_grant == PORT_D) ? PORT_F : PORT_D;
    end else if (d_req) begin
      win_c = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store:
// grant, one RAM access cycle, then a one-cycle acknowledge with read data.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_f_req,
  input  logic [ADDR_W-1:0] i_f_addr,
  output logic              o_f_ack,
  output logic [DATA_W-1:0] o_f_rdata,
  output logic              o_f_err,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_err,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_busy
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              lat_id_q, lat_id_d;
  logic              lat_we_q, lat_we_d;
  logic              lat_ok_q, lat_ok_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              f_err_q, f_err_d;
  logic              d_err_q, d_err_d;
  logic              busy_q, busy_d;

  logic              win_c;
  logic              valid_c;
  logic              grant_we_c;
  logic [ADDR_W-1:0] grant_addr_c;
  logic [DATA_W-1:0] grant_wdata_c;
  logic [DATA_W-1:0] acc_rdata_c;

  mem_rr_pick u_pick (
    .f_req      (i_f_req),
    .d_req      (i_d_req),
    .last_grant (last_q),
    .win_c      (win_c),
    .valid_c    (valid_c)
  );

  // Attributes of the winning request; fetch never writes.
  always_comb begin
    grant_we_c    = 1'b0;
    grant_addr_c  = i_f_addr;
    grant_wdata_c = '0;
    if (win_c == PORT_D) begin
      grant_we_c    = i_d_we;
      grant_addr_c  = i_d_addr;
      grant_wdata_c = i_d_wdata;
    end
  end

  assign acc_rdata_c = (lat_we_q || !lat_ok_q) ? '0 : i_ram_rdata;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    lat_id_d    = lat_id_q;
    lat_we_d    = lat_we_q;
    lat_ok_d    = lat_ok_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    f_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    f_err_d     = f_err_q;
    d_err_d     = d_err_q;

    case (state_q)
      IDLE: begin
        if (valid_c) begin
          state_d     = ACCESS;
          last_d      = win_c;
          lat_id_d    = win_c;
          lat_we_d    = grant_we_c;
          lat_ok_d    = addr_in_range(grant_addr_c);
          ram_we_d    = grant_we_c & addr_in_range(grant_addr_c);
          ram_addr_d  = grant_addr_c;
          ram_wdata_d = grant_wdata_c;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (lat_id_q == PORT_D) begin
          d_ack_d   = 1'b1;
          d_rdata_d = acc_rdata_c;
          d_err_d   = ~lat_ok_q;
        end else begin
          f_ack_d   = 1'b1;
          f_rdata_d = acc_rdata_c;
          f_err_d   = ~lat_ok_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      last_q      <= PORT_D;
      lat_id_q    <= PORT_F;
      lat_we_q    <= 1'b0;
      lat_ok_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      f_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lat_id_q    <= lat_id_d;
      lat_we_q    <= lat_we_d;
      lat_ok_q    <= lat_ok_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      f_err_q     <= f_err_d;
      d_err_q     <= d_err_d;
      busy_q      <= busy_d;
    end
  end

  assign o_ram_we    = ram_we_q;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_wdata = ram_wdata_q;
  assign o_f_ack     = f_ack_q;
  assign o_d_ack     = d_ack_q;
  assign o_f_rdata   = f_rdata_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_f_err     = f_err_q;
  assign o_d_err     = d_err_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a falling-edge-write RAM model plus
// an expected-ack queue filled as requests are issued.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_f_req;
  logic [15:0] i_f_addr;
  logic        o_f_ack;
  logic [15:0] o_f_rdata;
  logic        o_f_err;
  logic        i_d_req;
  logic        i_d_we;
  logic [15:0] i_d_addr;
  logic [15:0] i_d_wdata;
  logic        o_d_ack;
  logic [15:0] o_d_rdata;
  logic        o_d_err;
  logic        o_ram_we;
  logic [15:0] o_ram_addr;
  logic [15:0] o_ram_wdata;
  logic [15:0] i_ram_rdata;
  logic        o_busy;

  mem_arbiter dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_f_req     (i_f_req),
    .i_f_addr    (i_f_addr),
    .o_f_ack     (o_f_ack),
    .o_f_rdata   (o_f_rdata),
    .o_f_err     (o_f_err),
    .i_d_req     (i_d_req),
    .i_d_we      (i_d_we),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .o_d_ack     (o_d_ack),
    .o_d_rdata   (o_d_rdata),
    .o_d_err     (o_d_err),
    .o_ram_we    (o_ram_we),
    .o_ram_addr  (o_ram_addr),
    .o_ram_wdata (o_ram_wdata),
    .i_ram_rdata (i_ram_rdata),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        port;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ram     [0:8];
  logic [15:0] ref_mem [0:8];
  int          vectors   = 0;
  int          miscompares = 0;
  int          cyc       = 0;
  int          last_ack  = -1;
  logic        gap_chk   = 1'b0;

  // RAM environment: falling-edge write, combinational read, junk when out of range.
  always @(negedge i_clk)
    if (o_ram_we && o_ram_addr < 16'd9) ram[o_ram_addr[3:0]] <= o_ram_wdata;
  assign i_ram_rdata = (o_ram_addr < 16'd9) ? ram[o_ram_addr[3:0]] : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pops and compares every acknowledge.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      cyc++;
      if (o_f_ack && o_d_ack) chk("ack_overlap", 32'(1), 32'(0));
      if (o_f_ack || o_d_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_port", 32'(o_d_ack), 32'(e.port));
          chk("ack_rdata", 32'(o_d_ack ? o_d_rdata : o_f_rdata), 32'(e.rdata));
          chk("ack_err", 32'(o_d_ack ? o_d_err : o_f_err), 32'(e.err));
        end
        if (gap_chk && last_ack >= 0) chk("ack_gap", 32'(cyc - last_ack), 32'(3));
        last_ack = cyc;
      end
    end
  end

  function automatic exp_t predict(input logic port, input logic we,
                                   input logic [15:0] addr, input logic [15:0] wdata);
    exp_t e;
    logic ok;
    ok      = addr < 16'd9;
    e.port  = port;
    e.err   = ~ok;
    e.rdata = (we || !ok) ? 16'h0 : ref_mem[addr[3:0]];
    if (we && ok) ref_mem[addr[3:0]] = wdata;
    return e;
  endfunction

  // Single uncontended access with latency and RAM-drive checks.
  task automatic access(input logic port, input logic we,
                        input logic [15:0] addr, input logic [15:0] wdata);
    logic ok;
    int   n;
    ok = addr < 16'd9;
    exp_q.push_back(predict(port, we, addr, wdata));
    @(negedge i_clk);
    if (port == 1'b1) begin
      i_d_req = 1'b1; i_d_we = we; i_d_addr = addr; i_d_wdata = wdata;
    end else begin
      i_f_req = 1'b1; i_f_addr = addr;
    end
    @(negedge i_clk);
    chk("access_addr", 32'(o_ram_addr), 32'(addr));
    chk("access_we", 32'(o_ram_we), 32'(we && ok));
    if (we) chk("access_wdata", 32'(o_ram_wdata), 32'(wdata));
    chk("access_busy", 32'(o_busy), 32'(1));
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(port ? o_d_ack : o_f_ack) && n < 10);
    chk("ack_latency", 32'(n), 32'(1));
    chk("resp_we", 32'(o_ram_we), 32'(0));
    i_f_req = 1'b0;
    i_d_req = 1'b0;
    @(negedge i_clk);
    chk("idle_busy", 32'(o_busy), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_f"}, 32'({o_f_ack, o_f_err, o_f_rdata}), 32'(0));
    chk({tag, "_d"}, 32'({o_d_ack, o_d_err, o_d_rdata}), 32'(0));
    chk({tag, "_ram"}, {o_ram_we, o_ram_addr[14:0], o_ram_wdata}, 32'(0));
    chk({tag, "_ram_addr_msb"}, 32'(o_ram_addr[15]), 32'(0));
    chk({tag, "_busy"}, 32'(o_busy), 32'(0));
  endtask

  initial begin
    int seen;
    int n;
    i_rst = 1'b1;
    i_f_req = 1'b0; i_f_addr = '0;
    i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = '0; i_d_wdata = '0;
    for (int i = 0; i < 9; i++) begin
      ram[i]     = 16'h1000 + 16'(i);
      ref_mem[i] = 16'h1000 + 16'(i);
    end
    ram[3]     = 16'h8301;
    ref_mem[3] = 16'h8301;
    repeat (2) @(negedge i_clk);
    check_reset_outputs("por");
    i_rst = 1'b0;

    access(1'b0, 1'b0, 16'd3, 16'h0);
    access(1'b1, 1'b1, 16'd7, 16'hBEEF);
    access(1'b1, 1'b0, 16'd7, 16'h0);
    access(1'b1, 1'b1, 16'd9, 16'h1234);
    access(1'b0, 1'b0, 16'hFFFF, 16'h0);
    access(1'b0, 1'b0, 16'd8, 16'h0);
    access(1'b1, 1'b0, 16'd3, 16'h0);

    // Mid-run reset with populated output registers.
    @(negedge i_clk);
    i_rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      chk("idle_we", 32'({o_ram_we, o_busy}), 32'(0));
    end

    // Both ports held: fetch first after reset, then strict alternation.
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(predict(1'b0, 1'b0, 16'd3, 16'h0));
      exp_q.push_back(predict(1'b1, 1'b0, 16'd7, 16'h0));
    end
    gap_chk  = 1'b1;
    last_ack = -1;
    i_f_req = 1'b1; i_f_addr = 16'd3;
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 16'd7;
    seen = 0;
    n = 0;
    while (seen < 4 && n < 40) begin
      @(negedge i_clk);
      n++;
      if (o_f_ack || o_d_ack) seen++;
    end
    chk("alt_acks", 32'(seen), 32'(4));
    i_f_req = 1'b0;
    i_d_req = 1'b0;
    gap_chk = 1'b0;
    repeat (2) @(negedge i_clk);

    // Reset lands inside the ACCESS cycle of a store, before the falling edge.
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 16'd2; i_d_wdata = 16'h5555;
    @(posedge i_clk);
    #1 chk("pre_rst_we", 32'(o_ram_we), 32'(1));
    i_rst = 1'b1;
    #1 chk("rst_we_drop", 32'({o_ram_we, o_busy, o_d_ack}), 32'(0));
    @(negedge i_clk);
    chk("rst_store_lost", 32'(ram[2]), 32'(ref_mem[2]));
    i_d_req = 1'b0;
    i_d_we  = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_no_ack", 32'(exp_q.size()), 32'(0));

    exp_q.push_back(predict(1'b0, 1'b0, 16'd5, 16'h0));
    exp_q.push_back(predict(1'b1, 1'b0, 16'd2, 16'h0));
    i_f_req = 1'b1; i_f_addr = 16'd5;
    i_d_req = 1'b1; i_d_addr = 16'd2;
    seen = 0;
    n = 0;
    while (seen < 2 && n < 20) begin
      @(negedge i_clk);
      n++;
      if (o_f_ack) begin i_f_req = 1'b0; seen++; end
      if (o_d_ack) begin i_d_req = 1'b0; seen++; end
    end
    chk("post_rst_acks", 32'(seen), 32'(2));
    i_f_req = 1'b0;
    i_d_req = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the processor's single-port 16-bit program/data RAM. It shares the one RAM port between the instruction-fetch path (read-only) and the load/store path (read/write). It latches each granted request, drives the RAM for exactly one access cycle, and returns read data with a one-cycle acknowledge. It sits between the core's fetch/execute logic and the RAM, whose write commits on the falling clock edge and whose read is combinational.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, address width
- MEM_DEPTH, 9, number of implemented RAM words; addresses >= MEM_DEPTH are out of range

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_f_req  in  1  fetch request; held high until o_f_ack
- i_f_addr  in  ADDR_W  fetch address
- o_f_ack  out  1  one-cycle fetch completion pulse
- o_f_rdata  out  DATA_W  fetch read data, valid while o_f_ack=1
- o_f_err  out  1  out-of-range fetch, valid while o_f_ack=1
- i_d_req  in  1  data request; held high until o_d_ack
- i_d_we  in  1  1 = store, 0 = load
- i_d_addr  in  ADDR_W  data address
- i_d_wdata  in  DATA_W  store data
- o_d_ack  out  1  one-cycle data completion pulse
- o_d_rdata  out  DATA_W  load data, valid while o_d_ack=1; 0 for stores
- o_d_err  out  1  out-of-range data access, valid while o_d_ack=1
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_wdata  out  DATA_W  RAM write data
- i_ram_rdata  in  DATA_W  RAM combinational read data
- o_busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if either request is high, select a winner and latch its id, we, addr and wdata into registers; go to ACCESS. Otherwise stay in IDLE.
- Winner selection:
  - Only one request high: that port wins.
  - Both high: round-robin. The port not granted last wins. The last-grant pointer updates on each grant.
- ACCESS:
  - o_ram_addr and o_ram_wdata come from the latched registers.
  - o_ram_we = latched we AND in-range. The RAM commits the write on the falling edge within this cycle.
  - At the rising edge that ends ACCESS: capture i_ram_rdata for loads and fetches, or 0 for stores and out-of-range accesses. Set the err flag to out-of-range. Go to RESP.
- RESP: assert the ack for the granted port only; rdata and err are driven from registers. Next state is always IDLE, so the still-high request of the served port is never re-arbitrated.
- Range check: an address is in range when it is less than MEM_DEPTH, compared on the full ADDR_W bits. Out-of-range writes are suppressed, out-of-range reads return 0, and err=1.
- Fetch port never writes; the fetch latched we is forced to 0.
- Request attributes are latched at grant. Changes after grant are ignored. Dropping a request before its ack is a protocol violation; the access still completes and the ack still pulses.
- o_ram_we is 0 in IDLE and RESP.
- Pending losing request remains pending and wins the next IDLE arbitration if the other port re-requests, per round-robin.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All outputs go to 0, including o_ram_addr, o_ram_wdata, rdata and err.
  - Last-grant pointer set to data, so fetch wins the first tie.
- Reset mid-ACCESS: o_ram_we drops immediately. A write whose falling edge has not yet occurred is lost; no ack is issued.
- Latency: request seen high in IDLE at edge N, RAM driven in cycle N+1, ack high in cycle N+2.
- Throughput: one access per 3 cycles; the pending port starts at the earliest 1 cycle after the other port's RESP.
- Exactly one ack per grant; o_f_ack and o_d_ack are never high together.
- o_busy = (state != IDLE).

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP)
  - port-id constants PORT_F=0 and PORT_D=1
  - default widths and MEM_DEPTH
- One natural sub-module: mem_rr_pick.
  - Combinational 2-way round-robin picker.
  - Inputs: two requests and the last-grant pointer.
  - Outputs: winner id and a valid flag.
  - The pointer register lives in mem_arbiter.

## Test plan
- Reset and idle: assert i_rst mid-simulation → all outputs 0, o_busy=0; with no requests, o_ram_we stays 0 for 10 cycles.
- Fetch read: RAM word 3 = 16'h8301, i_f_req with addr 3 → o_ram_addr=3 in cycle N+1, o_f_ack=1 with o_f_rdata=16'h8301 and o_f_err=0 in cycle N+2, then back to IDLE.
- Store then load: data store of 16'hBEEF to addr 7 → o_ram_we=1 for exactly one cycle and o_d_rdata=0; a following load of addr 7 → o_d_rdata=16'hBEEF.
- Simultaneous requests: both held high continuously after reset → acks alternate F, D, F, D, each 3 cycles apart, and never overlap.
- Out of range: store of 16'h1234 to addr 9 → o_ram_we stays 0, o_d_err=1 with ack; a fetch of addr 16'hFFFF → o_f_rdata=0, o_f_err=1.
- Reset during ACCESS of a store → o_ram_we drops immediately, no ack is issued, and the next request arbitrates normally with fetch preferred.
